id_stage_hs: RTL and testbench

//  Parametrised decode stage with valid/ready handshake: decodes one instruction per cycle,

---
 rtl/id_stage_hs_if.sv | 31 +++
 rtl/id_stage_hs.sv | 188 ++++++++++++++++++
 tb/tb_id_stage_hs.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_hs_if.sv
// Fetch / write-back / execute signal bundle around the decode stage.
// master = pipeline neighbours (fetch, write-back, execute), slave = decode stage.
interface id_stage_hs_if #(
  parameter int DATA_W = 64,
  parameter int INST_W = 32
);
  logic              i_inst_valid;
  logic              o_inst_ready;
  logic [INST_W-1:0] i_inst;
  logic              i_wb_valid;
  logic [4:0]        i_wb_rd;
  logic [DATA_W-1:0] i_wb_data;
  logic              o_valid;
  logic              i_ready;
  logic [3:0]        o_op;
  logic [DATA_W-1:0] o_rs1;
  logic [DATA_W-1:0] o_rs2;
  logic [DATA_W-1:0] o_imm;
  logic [4:0]        o_rd_id;
  logic              o_finish;

  modport master (
    output i_inst_valid, i_inst, i_wb_valid, i_wb_rd, i_wb_data, i_ready,
    input  o_inst_ready, o_valid, o_op, o_rs1, o_rs2, o_imm, o_rd_id, o_finish
  );

  modport slave (
    input  i_inst_valid, i_inst, i_wb_valid, i_wb_rd, i_wb_data, i_ready,
    output o_inst_ready, o_valid, o_op, o_rs1, o_rs2, o_imm, o_rd_id, o_finish
  );
endinterface

// File: rtl/id_stage_hs.sv
// Decode stage: regfile read with write-back bypass, immediate extension, load-use stall, sticky STOP.
// Latency 1; the output register holds under i_ready=0 and stalls fetch via o_inst_ready.
module id_stage_hs #(
  parameter int DATA_W     = 64,
  parameter int INST_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int LOAD_STALL = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  id_stage_hs_if.slave bus
);
  localparam int         RIDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [5:0] REG_LIM = 6'(REG_NUM);
  localparam int         CNT_W   = (LOAD_STALL > 0) ? $clog2(LOAD_STALL + 1) : 1;

  typedef enum logic [3:0] {
    OP_LD, OP_SD, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_ILL
  } op_e;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rd;
  } bundle_t;

  function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
    return {{(DATA_W-12){v[11]}}, v};
  endfunction

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < REG_LIM;
  endfunction

  logic [DATA_W-1:0] regs [REG_NUM];
  bundle_t           out_q;
  logic              out_vld;
  logic              out_ld;
  logic              finish_q;
  logic              ld_pend;
  logic              ld_cnting;
  logic [4:0]        ld_rd;
  logic [CNT_W-1:0]  ld_cnt;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;

  assign inst   = bus.i_inst[31:0];
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  op_e               op;
  logic              use_rs1, use_rs2, use_rd, is_stop;
  logic [DATA_W-1:0] imm_ext;

  // Unused fields are reported as zero so an operand never leaks unrelated register state.
  always_comb begin
    op      = OP_ILL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_stop = 1'b0;
    imm_ext = '0;
    case ({f3, opcode})
      {3'd3, 7'h03}: begin op = OP_LD;  use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = sext12(inst[31:20]); end
      {3'd3, 7'h23}: begin op = OP_SD;  use_rs1 = 1'b1; use_rs2 = 1'b1; imm_ext = sext12({f7, inst[11:7]}); end
      {3'd0, 7'h63}: begin op = OP_BEQ; use_rs1 = 1'b1; use_rs2 = 1'b1;
                           imm_ext = sext12({inst[31], inst[7], inst[30:25], inst[11:8]}); end
      {3'd1, 7'h63}: begin op = OP_BNE; use_rs1 = 1'b1; use_rs2 = 1'b1;
                           imm_ext = sext12({inst[31], inst[7], inst[30:25], inst[11:8]}); end
      {3'd0, 7'h13}: begin op = OP_ADDI; use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = sext12(inst[31:20]); end
      {3'd4, 7'h13}: begin op = OP_XORI; use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = sext12(inst[31:20]); end
      {3'd6, 7'h13}: begin op = OP_ORI;  use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = sext12(inst[31:20]); end
      {3'd7, 7'h13}: begin op = OP_ANDI; use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = sext12(inst[31:20]); end
      {3'd1, 7'h13}: begin op = OP_SLLI; use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = DATA_W'(inst[25:20]); end
      {3'd5, 7'h13}: begin op = OP_SRLI; use_rs1 = 1'b1; use_rd = 1'b1; imm_ext = DATA_W'(inst[25:20]); end
      {3'd0, 7'h33}: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          op = (f7 == 7'h20) ? OP_SUB : OP_ADD;
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        end
      end
      {3'd4, 7'h33}: if (f7 == 7'h00) begin op = OP_XOR; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      {3'd6, 7'h33}: if (f7 == 7'h00) begin op = OP_OR;  use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      {3'd7, 7'h33}: if (f7 == 7'h00) begin op = OP_AND; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; end
      {3'd7, 7'h7F}: is_stop = 1'b1;
      default: ;
    endcase
    if ((use_rs1 && !in_range(rs1)) || (use_rs2 && !in_range(rs2)) || (use_rd && !in_range(rd))) begin
      op      = OP_ILL;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      imm_ext = '0;
    end
  end

  logic [DATA_W-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1 != 5'd0)
      rs1_val = (bus.i_wb_valid && bus.i_wb_rd == rs1) ? bus.i_wb_data : regs[rs1[RIDX_W-1:0]];
    if (use_rs2 && rs2 != 5'd0)
      rs2_val = (bus.i_wb_valid && bus.i_wb_rd == rs2) ? bus.i_wb_data : regs[rs2[RIDX_W-1:0]];
  end

  logic hazard, accept, fire, ld_acc;

  assign hazard = ld_pend && ((use_rs1 && rs1 == ld_rd) || (use_rs2 && rs2 == ld_rd));
  assign bus.o_inst_ready = !finish_q && !hazard && (!out_vld || bus.i_ready);
  assign accept = bus.i_inst_valid && bus.o_inst_ready;
  assign fire   = out_vld && bus.i_ready;
  assign ld_acc = accept && op == OP_LD && rd != 5'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (bus.i_wb_valid && bus.i_wb_rd != 5'd0 && in_range(bus.i_wb_rd)) begin
      regs[bus.i_wb_rd[RIDX_W-1:0]] <= bus.i_wb_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q     <= '0;
      out_vld   <= 1'b0;
      out_ld    <= 1'b0;
      finish_q  <= 1'b0;
      ld_pend   <= 1'b0;
      ld_cnting <= 1'b0;
      ld_rd     <= '0;
      ld_cnt    <= '0;
    end else begin
      if (accept && !is_stop) begin
        out_vld   <= 1'b1;
        out_ld    <= ld_acc;
        out_q.op  <= op;
        out_q.rs1 <= rs1_val;
        out_q.rs2 <= rs2_val;
        out_q.imm <= imm_ext;
        out_q.rd  <= use_rd ? rd : 5'd0;
      end else if (fire) begin
        out_vld <= 1'b0;
        out_ld  <= 1'b0;
      end
      if (accept && is_stop) finish_q <= 1'b1;
      // The stall window opens when the load leaves; a newer load always takes over.
      if (ld_acc) begin
        ld_pend   <= 1'b1;
        ld_rd     <= rd;
        ld_cnting <= 1'b0;
      end else if (fire && out_ld) begin
        if (LOAD_STALL == 0) begin
          ld_pend <= 1'b0;
        end else begin
          ld_cnting <= 1'b1;
          ld_cnt    <= CNT_W'(LOAD_STALL);
        end
      end else if (ld_cnting) begin
        ld_cnt <= ld_cnt - 1'b1;
        if (ld_cnt <= CNT_W'(1)) begin
          ld_pend   <= 1'b0;
          ld_cnting <= 1'b0;
        end
      end
    end
  end

  assign bus.o_valid  = out_vld;
  assign bus.o_op     = out_q.op;
  assign bus.o_rs1    = out_q.rs1;
  assign bus.o_rs2    = out_q.rs2;
  assign bus.o_imm    = out_q.imm;
  assign bus.o_rd_id  = out_q.rd;
  assign bus.o_finish = finish_q;
endmodule

// File: tb/tb_id_stage_hs.sv
// Bench for id_stage_hs (REG_NUM=16): directed instructions with a bundle scoreboard.
module tb_id_stage_hs;
  localparam int LOAD_STALL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_stage_hs_if #(.DATA_W(64), .INST_W(32)) bus ();

  id_stage_hs #(.DATA_W(64), .INST_W(32), .REG_NUM(16), .LOAD_STALL(LOAD_STALL)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] imm, input logic [4:0] rd);
    exp_t e;
    e.op = op; e.rs1 = a; e.rs2 = b; e.imm = imm; e.rd = rd;
    return e;
  endfunction

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Scoreboard side: every bundle taken by execute must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle op=%0d expected=none", bus.o_op);
      end else begin
        mon_e = sb.pop_front();
        chk("op",  64'(bus.o_op),    64'(mon_e.op));
        chk("rs1", bus.o_rs1,        mon_e.rs1);
        chk("rs2", bus.o_rs2,        mon_e.rs2);
        chk("imm", bus.o_imm,        mon_e.imm);
        chk("rd",  64'(bus.o_rd_id), 64'(mon_e.rd));
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input exp_t e, input bit has_out, output int stalls);
    bus.i_inst       = ins;
    bus.i_inst_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!bus.o_inst_ready && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.o_inst_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%h stalls=%0d expected=accept", ins, stalls);
    end else begin
      @(posedge clk);
      if (has_out) sb.push_back(e);
    end
    #1;
    bus.i_inst_valid = 1'b0;
    bus.i_wb_valid   = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = r;
    bus.i_wb_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bus.i_inst_valid = 1'b0;
    bus.i_inst       = '0;
    bus.i_wb_valid   = 1'b0;
    bus.i_wb_rd      = '0;
    bus.i_wb_data    = '0;
    bus.i_ready      = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid",  64'(bus.o_valid),      64'd0);
    chk("rst_finish", 64'(bus.o_finish),     64'd0);
    chk("rst_op",     64'(bus.o_op),         64'd0);
    chk("rst_imm",    bus.o_imm,             64'd0);
    chk("rst_ready",  64'(bus.o_inst_ready), 64'd1);
    idle(1);

    // ALU path, bypass vs regfile, x0 protection, out-of-range write-back
    issue(i_t(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), mk(4, 0, 0, 5, 1), 1'b1, st);
    wb(5'd1, 64'd5);
    issue(r_t(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), mk(10, 5, 5, 0, 2), 1'b1, st);
    issue(r_t(7'h00, 5'd1, 5'd1, 3'd0, 5'd6), mk(10, 5, 5, 0, 6), 1'b1, st);
    wb(5'd1, 64'd7);
    issue(r_t(7'h00, 5'd0, 5'd1, 3'd0, 5'd7), mk(10, 7, 0, 0, 7), 1'b1, st);
    wb(5'd0, 64'hFF);
    issue(r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), mk(10, 0, 0, 0, 8), 1'b1, st);
    issue(r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd8), mk(10, 0, 0, 0, 8), 1'b1, st);
    wb(5'd17, 64'hDEAD);
    issue(r_t(7'h00, 5'd0, 5'd1, 3'd0, 5'd9), mk(10, 7, 0, 0, 9), 1'b1, st);

    // Immediate formats
    issue({1'b1, 6'h3F, 5'd2, 5'd1, 3'd0, 4'hF, 1'b1, 7'h63}, mk(2, 7, 0, ONES, 0), 1'b1, st);
    issue({7'h7F, 5'd1, 5'd2, 3'd3, 5'h18, 7'h23}, mk(1, 0, 7, 64'hFFFF_FFFF_FFFF_FFF8, 0), 1'b1, st);
    issue({6'd0, 6'd63, 5'd1, 3'd1, 5'd3, 7'h13}, mk(8, 7, 0, 63, 3), 1'b1, st);
    issue(i_t(12'hFFF, 5'd1, 3'd4, 5'd4, 7'h13), mk(5, 7, 0, ONES, 4), 1'b1, st);
    issue(r_t(7'h20, 5'd0, 5'd1, 3'd0, 5'd5), mk(11, 7, 0, 0, 5), 1'b1, st);

    // Illegal encodings
    issue(r_t(7'h01, 5'd2, 5'd1, 3'd0, 5'd5), mk(15, 0, 0, 0, 0), 1'b1, st);
    issue(r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd17), mk(15, 0, 0, 0, 0), 1'b1, st);
    issue({25'd0, 7'h37}, mk(15, 0, 0, 0, 0), 1'b1, st);
    idle(2);

    // Downstream backpressure holds the bundle and blocks fetch
    bus.i_ready = 1'b0;
    issue(i_t(12'd3, 5'd1, 3'd7, 5'd6, 7'h13), mk(7, 7, 0, 3, 6), 1'b1, st);
    bus.i_inst       = i_t(12'd8, 5'd1, 3'd6, 5'd7, 7'h13);
    bus.i_inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_inst_ready", 64'(bus.o_inst_ready), 64'd0);
      chk("hold_valid",      64'(bus.o_valid),      64'd1);
      chk("hold_op",         64'(bus.o_op),         64'd7);
      chk("hold_rs1",        bus.o_rs1,             64'd7);
      chk("hold_imm",        bus.o_imm,             64'd3);
    end
    @(posedge clk);
    #1 bus.i_ready = 1'b1;
    issue(i_t(12'd8, 5'd1, 3'd6, 5'd7, 7'h13), mk(6, 7, 0, 8, 7), 1'b1, st);
    chk("release_stalls", 64'(st), 64'd0);

    // Load-use
    issue(i_t(12'd16, 5'd1, 3'd3, 5'd3, 7'h03), mk(0, 7, 0, 16, 3), 1'b1, st);
    issue(r_t(7'h00, 5'd0, 5'd3, 3'd0, 5'd4), mk(10, 0, 0, 0, 4), 1'b1, st);
    chk("ld_use_rs1_stalls", 64'(st), 64'(1 + LOAD_STALL));
    issue(i_t(12'd16, 5'd1, 3'd3, 5'd3, 7'h03), mk(0, 7, 0, 16, 3), 1'b1, st);
    issue(i_t(12'd1, 5'd0, 3'd0, 5'd5, 7'h13), mk(4, 0, 0, 1, 5), 1'b1, st);
    chk("ld_indep_stalls", 64'(st), 64'd0);
    issue(i_t(12'd16, 5'd1, 3'd3, 5'd3, 7'h03), mk(0, 7, 0, 16, 3), 1'b1, st);
    issue({7'd0, 5'd3, 5'd0, 3'd3, 5'd0, 7'h23}, mk(1, 0, 0, 0, 0), 1'b1, st);
    chk("ld_use_rs2_stalls", 64'(st), 64'(1 + LOAD_STALL));

    // STOP behind a pending bundle
    issue(i_t(12'd1, 5'd0, 3'd6, 5'd9, 7'h13), mk(6, 0, 0, 1, 9), 1'b1, st);
    issue({17'd0, 3'd7, 5'd0, 7'h7F}, mk(0, 0, 0, 0, 0), 1'b0, st);
    @(negedge clk);
    chk("stop_finish", 64'(bus.o_finish),     64'd1);
    chk("stop_valid",  64'(bus.o_valid),      64'd0);
    bus.i_inst       = i_t(12'd9, 5'd0, 3'd0, 5'd1, 7'h13);
    bus.i_inst_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("stop_inst_ready", 64'(bus.o_inst_ready), 64'd0);
      @(negedge clk);
    end
    bus.i_inst_valid = 1'b0;

    // Reset clears finish, then reset again in the middle of a load-use stall
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rst_clears_finish", 64'(bus.o_finish), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(i_t(12'd16, 5'd1, 3'd3, 5'd3, 7'h03), mk(0, 0, 0, 16, 3), 1'b1, st);
    bus.i_inst       = r_t(7'h00, 5'd0, 5'd3, 3'd0, 5'd4);
    bus.i_inst_valid = 1'b1;
    @(negedge clk);
    chk("mid_stall_ready", 64'(bus.o_inst_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.o_valid),      64'd0);
    chk("arst_imm",   bus.o_imm,             64'd0);
    chk("arst_rd",    64'(bus.o_rd_id),      64'd0);
    chk("arst_ready", 64'(bus.o_inst_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(r_t(7'h00, 5'd0, 5'd3, 3'd0, 5'd4), mk(10, 0, 0, 0, 4), 1'b1, st);
    chk("post_rst_stalls", 64'(st), 64'd0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
